// File: rtl/ymz_pkg.sv
// ymz_pkg: shared definitions for the YMZ294/PSG bus receiver.
//   - PSG register index constants
//   - per-register implemented width table and the store mask helper
//   - decode FSM state type and the write event record
package ymz_pkg;

  localparam int unsigned NUM_REGS_C = 16;

  localparam logic [3:0] R_TONE_A_L  = 4'd0;
  localparam logic [3:0] R_TONE_A_H  = 4'd1;
  localparam logic [3:0] R_TONE_B_L  = 4'd2;
  localparam logic [3:0] R_TONE_B_H  = 4'd3;
  localparam logic [3:0] R_TONE_C_L  = 4'd4;
  localparam logic [3:0] R_TONE_C_H  = 4'd5;
  localparam logic [3:0] R_NOISE     = 4'd6;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_AMP_A     = 4'd8;
  localparam logic [3:0] R_AMP_B     = 4'd9;
  localparam logic [3:0] R_AMP_C     = 4'd10;
  localparam logic [3:0] R_ENV_L     = 4'd11;
  localparam logic [3:0] R_ENV_H     = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_PORT_A    = 4'd14;
  localparam logic [3:0] R_PORT_B    = 4'd15;

  // Implemented bits per register, indexed by register number.
  localparam int unsigned REG_W [16] = '{8, 4, 8, 4, 8, 4, 5, 8,
                                         5, 5, 5, 8, 8, 4, 8, 8};

  typedef enum logic {
    NO_ADDR   = 1'b0,
    HAVE_ADDR = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_evt_t;

  // Clear the bits a register does not implement.
  function automatic logic [7:0] reg_mask(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] m;
    m = 8'hFF >> (8 - REG_W[a]);
    return d & m;
  endfunction

endpackage

// File: rtl/ymz_bus_sync.sv
// ymz_bus_sync: brings the asynchronous PSG write bus into clk.
//   Each bus bit passes through SYNC_STAGES flops (idle value cs_n=1, a0=0, d=0).
//   cap_a0/cap_d follow the synchronised a0/d while cs is low and hold once it
//   rises, so the captured byte is still valid in the cycle cs_rise fires.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bus_cs_n/bus_a0/bus_d raw asynchronous bus
//   cs_rise               1-clk pulse on synchronised cs_n rising edge
//   cap_a0, cap_d         captured cycle type and byte
module ymz_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_cs_n,
  input  logic       bus_a0,
  input  logic [7:0] bus_d,
  output logic       cs_rise,
  output logic       cap_a0,
  output logic [7:0] cap_d
);

  localparam logic [9:0] IDLE = {1'b1, 1'b0, 8'h00};

  // Stage 0 is nearest the pins; each word is {cs_n, a0, d}.
  logic [SYNC_STAGES-1:0][9:0] sync_pipe;
  logic                        cs_s, cs_s_q, a0_s;
  logic [7:0]                  d_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= {SYNC_STAGES{IDLE}};
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {bus_cs_n, bus_a0, bus_d}};
    end
  end

  assign cs_s = sync_pipe[SYNC_STAGES-1][9];
  assign a0_s = sync_pipe[SYNC_STAGES-1][8];
  assign d_s  = sync_pipe[SYNC_STAGES-1][7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s_q <= 1'b1;
      cap_a0 <= 1'b0;
      cap_d  <= 8'h00;
    end else begin
      cs_s_q <= cs_s;
      if (!cs_s) begin
        cap_a0 <= a0_s;
        cap_d  <= d_s;
      end
    end
  end

  assign cs_rise = cs_s & ~cs_s_q;

endmodule

// File: rtl/ymz_bus_receiver.sv
// ymz_bus_receiver: responder for the YMZ294/PSG parallel write bus.
//   Decodes address/data cycles, holds the 16x8 register file and emits
//   write strobes for the synth core.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   bus_cs_n/a0/d      asynchronous bus from the sound driver
//   regs_flat          register k at [8k+7:8k]
//   wr_stb             1-clk pulse per register write
//   wr_addr, wr_data   written index and stored value (valid with wr_stb)
//   env_restart        1-clk pulse on every write to R13
//   addr_valid         an in-range address is latched
// Build option: YMZ_REG_MASK_EN stores unimplemented register bits as 0.
module ymz_bus_receiver
  import ymz_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_cs_n,
  input  logic                  bus_a0,
  input  logic [7:0]            bus_d,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [3:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  env_restart,
  output logic                  addr_valid
);

  logic       cs_rise, cap_a0;
  logic [7:0] cap_d;

  ymz_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_cs_n (bus_cs_n),
    .bus_a0   (bus_a0),
    .bus_d    (bus_d),
    .cs_rise  (cs_rise),
    .cap_a0   (cap_a0),
    .cap_d    (cap_d)
  );

  state_e                     state_q, state_d;
  logic [3:0]                 addr_q, addr_d;
  logic                       do_write;
  wr_evt_t                    evt;
  logic [NUM_REGS-1:0][7:0]   regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NO_ADDR;
      addr_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // An out-of-range address drops the latched one, so later data cycles
  // are ignored until a valid address arrives.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    do_write = 1'b0;
    if (cs_rise) begin
      if (!cap_a0) begin
        if (cap_d[7:4] == 4'h0) begin
          addr_d  = cap_d[3:0];
          state_d = HAVE_ADDR;
        end else begin
          state_d = NO_ADDR;
        end
      end else if (state_q == HAVE_ADDR) begin
        do_write = 1'b1;
      end
    end
  end

  always_comb begin
    evt.addr = addr_q;
`ifdef YMZ_REG_MASK_EN
    evt.data = reg_mask(addr_q, cap_d);
`else
    evt.data = cap_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      wr_stb      <= 1'b0;
      wr_addr     <= 4'd0;
      wr_data     <= 8'h00;
      env_restart <= 1'b0;
    end else begin
      wr_stb      <= do_write;
      env_restart <= do_write && (evt.addr == R_ENV_SHAPE);
      if (do_write) begin
        regs_q[evt.addr] <= evt.data;
        wr_addr          <= evt.addr;
        wr_data          <= evt.data;
      end
    end
  end

  assign regs_flat  = regs_q;
  assign addr_valid = (state_q == HAVE_ADDR);

endmodule

// File: tb/tb_ymz_bus_receiver.sv
module tb_ymz_bus_receiver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bus_cs_n, bus_a0;
  logic [7:0]   bus_d;
  logic [127:0] regs_flat;
  logic         wr_stb, env_restart, addr_valid;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  ymz_bus_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_cs_n    (bus_cs_n),
    .bus_a0      (bus_a0),
    .bus_d       (bus_d),
    .regs_flat   (regs_flat),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .env_restart (env_restart),
    .addr_valid  (addr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       env;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d, input logic env);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.env  = env;
    exp_q.push_back(e);
  endtask

  // One complete bus cycle: cs_n low for 4 clocks, then a 6 clock gap.
  task automatic bus_cycle(input logic a0, input logic [7:0] d);
    @(negedge clk);
    bus_a0   = a0;
    bus_d    = d;
    bus_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 128'(wr_stb), 128'(1'b0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 128'(wr_addr), 128'(e.addr));
          check("wr_data", 128'(wr_data), 128'(e.data));
          check("env_restart", 128'(env_restart), 128'(e.env));
          check("reg_stored", 128'(regs_flat[e.addr*8 +: 8]), 128'(e.data));
        end
      end else if (env_restart) begin
        check("stray_env_restart", 128'(env_restart), 128'(1'b0));
      end
    end
  end

  logic [127:0] snap;
  logic [7:0]   reg1_exp;

  initial begin
    rst_n    = 1'b0;
    bus_cs_n = 1'b1;
    bus_a0   = 1'b0;
    bus_d    = 8'h00;
    repeat (3) @(negedge clk);

    // 1: reset state, then reset in the middle of a data cycle
    check("rst_regs", regs_flat, 128'd0);
    check("rst_wr_stb", 128'(wr_stb), 128'd0);
    check("rst_wr_addr", 128'(wr_addr), 128'd0);
    check("rst_wr_data", 128'(wr_data), 128'd0);
    check("rst_env", 128'(env_restart), 128'd0);
    check("rst_addr_valid", 128'(addr_valid), 128'd0);
    rst_n = 1'b1;
    bus_cycle(1'b0, 8'h03);
    check("addr_valid_set", 128'(addr_valid), 128'd1);
    @(negedge clk);
    bus_a0 = 1'b1; bus_d = 8'h55; bus_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_addr_valid", 128'(addr_valid), 128'd0);
    check("midrst_wr_stb", 128'(wr_stb), 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_regs", regs_flat, 128'd0);
    check("midrst_addr_valid_after", 128'(addr_valid), 128'd0);

    // 2: addr 7, data 0x38 with latency measured from the cs_n rise
    bus_cycle(1'b0, 8'h07);
    expect_wr(4'd7, 8'h38, 1'b0);
    @(negedge clk);
    bus_a0 = 1'b1; bus_d = 8'h38; bus_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_cs_n = 1'b1;
    @(negedge clk);
    check("lat_edge1", 128'(wr_stb), 128'd0);
    @(negedge clk);
    check("lat_edge2", 128'(wr_stb), 128'd0);
    @(negedge clk);
    check("lat_edge3", 128'(wr_stb), 128'd1);
    @(negedge clk);
    check("stb_one_clk", 128'(wr_stb), 128'd0);
    repeat (3) @(negedge clk);
    check("reg7", 128'(regs_flat[63:56]), 128'(8'h38));

    // 3: mask behaviour on R1
`ifdef YMZ_REG_MASK_EN
    reg1_exp = 8'h0F;
`else
    reg1_exp = 8'hFF;
`endif
    bus_cycle(1'b0, 8'h01);
    expect_wr(4'd1, reg1_exp, 1'b0);
    bus_cycle(1'b1, 8'hFF);
    check("reg1", 128'(regs_flat[15:8]), 128'(reg1_exp));

    // 4: envelope restart on every R13 write, none on R12
    bus_cycle(1'b0, 8'h0D);
    expect_wr(4'd13, 8'h0A, 1'b1);
    bus_cycle(1'b1, 8'h0A);
    expect_wr(4'd13, 8'h0A, 1'b1);
    bus_cycle(1'b1, 8'h0A);
    check("reg13", 128'(regs_flat[111:104]), 128'(8'h0A));
    bus_cycle(1'b0, 8'h0C);
    expect_wr(4'd12, 8'h05, 1'b0);
    bus_cycle(1'b1, 8'h05);
    check("reg12", 128'(regs_flat[103:96]), 128'(8'h05));

    // 5: out-of-range address drops the latched one
    snap = regs_flat;
    bus_cycle(1'b0, 8'h25);
    check("oor_addr_valid", 128'(addr_valid), 128'd0);
    bus_cycle(1'b1, 8'h11);
    check("oor_regs", regs_flat, snap);
    check("oor_addr_valid2", 128'(addr_valid), 128'd0);

    // 6: data without address after reset, then repeated data writes
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst2_regs", regs_flat, 128'd0);
    bus_cycle(1'b1, 8'h44);
    check("noaddr_regs", regs_flat, 128'd0);
    bus_cycle(1'b0, 8'h08);
    expect_wr(4'd8, 8'h10, 1'b0);
    bus_cycle(1'b1, 8'h10);
    expect_wr(4'd8, 8'h1F, 1'b0);
    bus_cycle(1'b1, 8'h1F);
    check("reg8", 128'(regs_flat[71:64]), 128'(8'h1F));
    check("addr_persist", 128'(addr_valid), 128'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
